// File: rtl/control_multicycle.sv
// control_multicycle
//   Multi-cycle control unit for the 16-opcode core. Each instruction is
//   sequenced through FETCH, DECODE, EXEC, MEM and WB, and only visits the
//   states its opcode needs. Memory accesses (FETCH and MEM) complete either
//   on a req/ack handshake with a timeout, or after a fixed number of cycles.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   0     | FETCH  : instruction read, address from PC
//   1     | DECODE : decode outputs valid, one cycle
//   2     | EXEC   : ALU / branch resolution, one cycle
//   3     | MEM    : data read (lw) or write (sw), address from ALU
//   4     | WB     : register-file write-back, one cycle
//
// Ports
//   clk, reset                 clock (rising edge), async active-low reset
//   opcode, eq, mem_ack        IR opcode field, ALU equality, memory done pulse
//   M13, M2, M457, M6, ALU     datapath mux selects and ALU operation
//   mem_req, change_address_flag, instruction_flag, pc_flag,
//   wr_en_rf, wr_en            memory and datapath strobes
//   state                      current state code
//   bus_err                    sticky memory-timeout flag
module control_multicycle #(
    parameter int OPC_W         = 4,
    parameter int ALU_W         = 4,
    parameter int MEM_HANDSHAKE = 1,
    parameter int MEM_LAT       = 2,
    parameter int MEM_TIMEOUT   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             eq,
    input  logic             mem_ack,
    output logic             M13,
    output logic             M2,
    output logic             M457,
    output logic             M6,
    output logic [ALU_W-1:0] ALU,
    output logic             mem_req,
    output logic             change_address_flag,
    output logic             instruction_flag,
    output logic             pc_flag,
    output logic             wr_en_rf,
    output logic             wr_en,
    output logic [2:0]       state,
    output logic             bus_err
);

    localparam int CNT_MAX = (MEM_LAT > MEM_TIMEOUT) ? MEM_LAT : MEM_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_bus_err;

    logic [3:0]       w_op4;
    logic             w_nop;
    logic             w_is_j, w_is_beq, w_is_bne, w_is_lw, w_is_sw;
    logic             w_access;
    logic             w_done;
    logic             w_tout;
    logic             w_dec_m457, w_dec_m6;
    logic [3:0]       w_dec_alu;

    assign w_op4    = opcode[3:0];
    // Any set bit above the 4-bit opcode turns the instruction into a NOP.
    assign w_nop    = (opcode >> 4) != '0;
    assign w_is_j   = !w_nop && (w_op4 == 4'h7);
    assign w_is_beq = !w_nop && (w_op4 == 4'h8);
    assign w_is_bne = !w_nop && (w_op4 == 4'h9);
    assign w_is_lw  = !w_nop && (w_op4 == 4'hE);
    assign w_is_sw  = !w_nop && (w_op4 == 4'hF);

    assign w_access = (r_state == S_FETCH) || (r_state == S_MEM);

    // r_cnt counts cycles already spent in the access state, so the N-th
    // cycle is the one where r_cnt == N-1. An ack in the timeout cycle wins.
    assign w_done = w_access && ((MEM_HANDSHAKE != 0) ? mem_ack
                                 : (r_cnt == CNT_W'(MEM_LAT - 1)));
    assign w_tout = w_access && (MEM_HANDSHAKE != 0) && !mem_ack
                    && (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        w_dec_m457 = 1'b0;
        w_dec_m6   = 1'b0;
        w_dec_alu  = 4'h0;
        if (!w_nop) begin
            case (w_op4)
                4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                    w_dec_m457 = 1'b1;
                    w_dec_alu  = w_op4;
                end
                4'hA, 4'hB, 4'hD: begin
                    w_dec_m457 = 1'b1;
                    w_dec_m6   = 1'b1;
                    w_dec_alu  = w_op4;
                end
                4'hC: begin
                    w_dec_m457 = 1'b1;
                    w_dec_m6   = 1'b1;
                    w_dec_alu  = 4'h4;
                end
                4'hE, 4'hF: begin
                    w_dec_m6   = 1'b1;
                    w_dec_alu  = 4'h4;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            if (w_tout)
                r_bus_err <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_done)
                    w_state_nxt = S_DECODE;
            end
            S_DECODE: w_state_nxt = S_EXEC;
            S_EXEC: begin
                if (w_nop || w_is_j || w_is_beq || w_is_bne)
                    w_state_nxt = S_FETCH;
                else if (w_is_lw || w_is_sw)
                    w_state_nxt = S_MEM;
                else
                    w_state_nxt = S_WB;
            end
            S_MEM: begin
                if (w_done)
                    w_state_nxt = w_is_lw ? S_WB : S_FETCH;
                else if (w_tout)
                    w_state_nxt = S_FETCH;
            end
            S_WB:    w_state_nxt = S_FETCH;
            default: w_state_nxt = S_FETCH;
        endcase

        // A timeout re-enters FETCH from itself, so it must restart the count.
        w_cnt_nxt = r_cnt;
        if ((w_state_nxt != r_state) || w_tout)
            w_cnt_nxt = '0;
        else if (r_cnt != CNT_W'(CNT_MAX))
            w_cnt_nxt = r_cnt + 1'b1;
    end

    always_comb begin
        M13                 = 1'b0;
        M2                  = 1'b0;
        M457                = 1'b0;
        M6                  = 1'b0;
        ALU                 = '0;
        mem_req             = 1'b0;
        change_address_flag = 1'b0;
        instruction_flag    = 1'b0;
        pc_flag             = 1'b0;
        wr_en_rf            = 1'b0;
        wr_en               = 1'b0;
        if (r_state != S_FETCH) begin
            M457 = w_dec_m457;
            M6   = w_dec_m6;
            ALU  = ALU_W'(w_dec_alu);
        end
        case (r_state)
            S_FETCH: begin
                mem_req             = !w_tout;
                change_address_flag = 1'b1;
                instruction_flag    = w_done;
            end
            S_EXEC: begin
                if (w_is_j) begin
                    M13     = 1'b1;
                    M2      = 1'b1;
                    pc_flag = 1'b1;
                end else if (w_is_beq) begin
                    M2      = eq;
                    pc_flag = 1'b1;
                end else if (w_is_bne) begin
                    M2      = !eq;
                    pc_flag = 1'b1;
                end else if (w_nop) begin
                    pc_flag = 1'b1;
                end
            end
            S_MEM: begin
                mem_req = !w_tout;
                wr_en   = w_is_sw && !w_tout;
                pc_flag = w_is_sw && w_done;
            end
            S_WB: begin
                wr_en_rf = 1'b1;
                pc_flag  = 1'b1;
            end
            default: ;
        endcase
        // The state register already sits in FETCH during reset; keep its
        // request and address select from leaking onto the bus.
        if (!reset) begin
            M13                 = 1'b0;
            M2                  = 1'b0;
            M457                = 1'b0;
            M6                  = 1'b0;
            ALU                 = '0;
            mem_req             = 1'b0;
            change_address_flag = 1'b0;
            instruction_flag    = 1'b0;
            pc_flag             = 1'b0;
            wr_en_rf            = 1'b0;
            wr_en               = 1'b0;
        end
    end

    assign state   = r_state;
    assign bus_err = r_bus_err;

endmodule
